// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_pkg
// Brief    : Kernel-mode encoding, window-length decode and psum widths shared
//            by the MAC column and its partial-sum accumulator.
// Revision : 1.0  initial release
// ============================================================================
package pe_pkg;

    localparam int DATA_WIDTH       = 8;
    localparam int OUT_WIDTH        = 2 * DATA_WIDTH;
    localparam int COLUMN_OUT_WIDTH = OUT_WIDTH + 3;
    localparam int ACC_WIDTH        = COLUMN_OUT_WIDTH + 3;

    localparam logic [1:0] MODE_4_3X3 = 2'b00;
    localparam logic [1:0] MODE_4X4   = 2'b01;
    localparam logic [1:0] MODE_5X5   = 2'b10;
    localparam logic [1:0] MODE_6X6   = 2'b11;

    // Window length K, 3..6 beats per kernel window.
    typedef logic [2:0] kernel_k_t;

    localparam kernel_k_t K_RESET = 3'd3;

    function automatic kernel_k_t mode_to_k(input logic [1:0] mode);
        case (mode)
            MODE_4_3X3: return 3'd3;
            MODE_4X4:   return 3'd4;
            MODE_5X5:   return 3'd5;
            default:    return 3'd6;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_psum_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : pe_psum_acc_if
// Brief    : Column-psum input stream and finished-result output stream of the
//            PE partial-sum accumulator.
// Revision : 1.0  initial release
// ============================================================================
interface pe_psum_acc_if
    import pe_pkg::*;
#(
    parameter int COLUMN_OUT_WIDTH = pe_pkg::COLUMN_OUT_WIDTH,
    parameter int ACC_WIDTH        = pe_pkg::ACC_WIDTH
);

    logic [COLUMN_OUT_WIDTH-1:0] i_psum_column;
    logic                        i_psum_valid;
    logic                        o_psum_ready;
    logic [ACC_WIDTH-1:0]        o_acc_data;
    logic                        o_acc_valid;
    logic                        i_acc_ready;

    // The accumulator: consumes psums, produces results.
    modport slave (
        input  i_psum_column,
        input  i_psum_valid,
        output o_psum_ready,
        output o_acc_data,
        output o_acc_valid,
        input  i_acc_ready
    );

    // The surrounding column / output buffer.
    modport master (
        output i_psum_column,
        output i_psum_valid,
        input  o_psum_ready,
        input  o_acc_data,
        input  o_acc_valid,
        output i_acc_ready
    );

endinterface
`default_nettype wire

// File: rtl/pe_acc_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : pe_acc_out_reg
// Brief    : One-entry valid/ready result register; optional ReLU on load
//            when PE_PSUM_ACC_RELU_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module pe_acc_out_reg #(
    parameter int ACC_WIDTH = 22
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_rst_n,
    input  wire logic                 i_load,
    input  wire logic [ACC_WIDTH-1:0] i_load_data,
    input  wire logic                 i_ready,
    output logic                      o_valid,
    output logic [ACC_WIDTH-1:0]      o_data,
    output logic                      o_can_accept
);

    logic                 r_valid;
    logic [ACC_WIDTH-1:0] r_data;
    logic [ACC_WIDTH-1:0] w_load_val;

`ifdef PE_PSUM_ACC_RELU_EN
    assign w_load_val = i_load_data[ACC_WIDTH-1] ? '0 : i_load_data;
`else
    assign w_load_val = i_load_data;
`endif

    // A load wins over a drain so back-to-back results never drop valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= w_load_val;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid      = r_valid;
    assign o_data       = r_data;
    assign o_can_accept = !r_valid || i_ready;

endmodule
`default_nettype wire

// File: rtl/pe_psum_acc.sv
`default_nettype none
// ============================================================================
// Module   : pe_psum_acc
// Brief    : Accumulates K column psums into one kernel-window result with
//            backpressure; optional ReLU via PE_PSUM_ACC_RELU_EN.
// Revision : 1.0  initial release
// ============================================================================
module pe_psum_acc
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int OUT_WIDTH        = 2 * DATA_WIDTH,
    parameter int COLUMN_OUT_WIDTH = OUT_WIDTH + 3,
    parameter int ACC_WIDTH        = COLUMN_OUT_WIDTH + 3
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst_n,
    input  wire logic [1:0] i_mode,
    input  wire logic       i_clear,
    pe_psum_acc_if.slave    bus,
    output logic            o_busy
);

    localparam int c_EXT_WIDTH = ACC_WIDTH - COLUMN_OUT_WIDTH;

    kernel_k_t                   r_k;
    logic      [2:0]             r_cnt;
    logic      [ACC_WIDTH-1:0]   r_acc;

    kernel_k_t                   w_k_eff;
    logic      [ACC_WIDTH-1:0]   w_psum_ext;
    logic      [ACC_WIDTH-1:0]   w_sum;
    logic                        w_psum_ready;
    logic                        w_beat;
    logic                        w_last;

    assign w_psum_ext = {{c_EXT_WIDTH{bus.i_psum_column[COLUMN_OUT_WIDTH-1]}},
                         bus.i_psum_column};

    // The mode is only honoured on the first beat of a window.
    assign w_k_eff = (r_cnt == 3'd0) ? mode_to_k(i_mode) : r_k;
    assign w_beat  = bus.i_psum_valid && w_psum_ready && !i_clear;
    assign w_last  = w_beat && (r_cnt == (w_k_eff - 3'd1));
    assign w_sum   = r_acc + w_psum_ext;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= 3'd0;
            r_k   <= K_RESET;
        end else if (i_clear) begin
            r_acc <= '0;
            r_cnt <= 3'd0;
        end else if (w_beat) begin
            if (r_cnt == 3'd0) begin
                r_k <= w_k_eff;
            end
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= 3'd0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    pe_acc_out_reg #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_out_reg (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (w_last),
        .i_load_data  (w_sum),
        .i_ready      (bus.i_acc_ready),
        .o_valid      (bus.o_acc_valid),
        .o_data       (bus.o_acc_data),
        .o_can_accept (w_psum_ready)
    );

    assign bus.o_psum_ready = w_psum_ready;
    assign o_busy           = (r_cnt != 3'd0);

endmodule
`default_nettype wire
